// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, GF(2^8) helpers and key-expansion state type
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int RK_W = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;
  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} kexp_state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic int slot_lo(input int nr, input int r);
    return RK_W * (nr - r);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box lookup
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

// File: rtl/key_schedule_gen.sv
// key_schedule_gen: sequential AES-128 key expansion, one round key per clock
module key_schedule_gen
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      start,
  input  logic [127:0]              key,
  output logic                      busy,
  output logic                      done,
  output logic                      schedule_valid,
  output logic [RK_W*(NR+1)-1:0]    keySchedule
);
  localparam logic [3:0] LAST = 4'(NR);
  kexp_state_t state, state_n;
  logic [127:0] w, nw;
  logic [31:0] rot, sub, temp;
  logic [7:0] rcon;
  logic [3:0] round;
  assign rot = {w[23:0], w[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*j +: 8]), .y(sub[8*j +: 8]));
  end
  assign temp = sub ^ {rcon, 24'h0};
  assign nw[127:96] = w[127:96] ^ temp;
  assign nw[95:64] = w[95:64] ^ nw[127:96];
  assign nw[63:32] = w[63:32] ^ nw[95:64];
  assign nw[31:0] = w[31:0] ^ nw[63:32];
  // State register
  always_ff @(posedge Clk) state <= Reset ? IDLE : state_n;
  // Next state; busy covers the whole expansion including the FINISH cycle
  always_comb begin
    state_n = (state == IDLE && start) ? EXPAND :
              (state == EXPAND && round == LAST) ? FINISH :
              (state == FINISH) ? IDLE : state;
    busy = state != IDLE;
  end
  // Working words, round counter, rcon, schedule slots and status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keySchedule <= '0;
      w <= '0;
      rcon <= '0;
      round <= '0;
      done <= 1'b0;
      schedule_valid <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (state == IDLE && start) begin
        keySchedule[slot_lo(NR, 0) +: RK_W] <= key;
        w <= key;
        rcon <= RCON_INIT;
        round <= 4'd1;
        schedule_valid <= 1'b0;
      end else if (state == EXPAND) begin
        keySchedule[slot_lo(NR, int'(round)) +: RK_W] <= nw;
        w <= nw;
        rcon <= xtime(rcon);
        round <= (round == LAST) ? round : round + 4'd1;
      end else if (state == FINISH) begin
        schedule_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_key_schedule_gen.sv
// tb_key_schedule_gen: scoreboard bench for key_schedule_gen against a word-level reference expansion
module tb_key_schedule_gen;
  logic Clk = 0, Reset = 1, start = 0;
  logic [127:0] key = '0;
  logic busy, done, schedule_valid;
  logic [1407:0] keySchedule;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] sb_t [256];
  typedef struct {logic [1407:0] s; int acc;} exp_t;
  exp_t q[$];
  logic prev_valid = 0;
  logic [1407:0] prev_sched = '0;
  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [7:0] RCT [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  key_schedule_gen dut (
    .Clk(Clk), .Reset(Reset), .start(start), .key(key), .busy(busy),
    .done(done), .schedule_valid(schedule_valid), .keySchedule(keySchedule)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 0;
    for (int i = 1; i < 256; i++) if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]], sb_t[t[31:24]]} ^ {RCT[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] slot(input logic [1407:0] s, input int r);
    return s[1407-128*r -: 128];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    start = 1;
    key = k;
    tick();
    start = 0;
    q.push_back('{expand(k), cyc});
    chk("busy_rise", 128'(busy), 128'd1);
  endtask

  task automatic run_exp(input logic [127:0] k, input bit g);
    start_key(k);
    for (int i = 0; i < 11; i++) begin
      start = g && i >= 1 && i <= 5;
      key = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 0;
    tick();
    chk("done_fall", 128'(done), 128'd0);
  endtask

  // Monitor: pops the scoreboard whenever done pulses and checks invariants every cycle
  always @(negedge Clk) begin
    exp_t e;
    if (schedule_valid && prev_valid) chk("stable", 128'(keySchedule != prev_sched), 128'd0);
    prev_valid = schedule_valid;
    prev_sched = keySchedule;
    if (done) begin
      chk("done_busy", 128'(busy), 128'd0);
      chk("done_valid", 128'(schedule_valid), 128'd1);
      if (q.size() == 0) chk("unexpected_done", 128'd1, 128'd0);
      else begin
        e = q.pop_front();
        chk("latency", 128'(cyc - e.acc), 128'd11);
        for (int r = 0; r < 11; r++)
          chk($sformatf("slot%0d", r), slot(keySchedule, r), slot(e.s, r));
      end
    end
  end

  initial begin
    logic [127:0] kb;
    for (int i = 0; i < 256; i++) sb_t[i] = sbox_ref(8'(i));
    Reset = 1;
    repeat (2) tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_valid", 128'(schedule_valid), 128'd0);
    chk("rst_sched", 128'(|keySchedule), 128'd0);
    Reset = 0;
    tick();
    run_exp(KA, 1);
    chk("a1_slot1", slot(keySchedule, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_slot10", slot(keySchedule, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_exp('0, 0);
    chk("z_slot0", slot(keySchedule, 0), 128'h0);
    chk("z_slot1", slot(keySchedule, 1), 128'h62636363626363636263636362636363);
    chk("z_slot10", slot(keySchedule, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    start_key(KA);
    repeat (4) tick();
    Reset = 1;
    tick();
    void'(q.pop_back());
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    chk("mid_rst_valid", 128'(schedule_valid), 128'd0);
    chk("mid_rst_sched", 128'(|keySchedule), 128'd0);
    Reset = 0;
    run_exp(KA, 0);
    kb = {$urandom, $urandom, $urandom, $urandom};
    start_key(KA);
    repeat (11) tick();
    chk("b2b_done", 128'(done), 128'd1);
    start_key(kb);
    chk("b2b_valid_drop", 128'(schedule_valid), 128'd0);
    repeat (11) tick();
    tick();
    chk("b2b_final", slot(keySchedule, 10), slot(expand(kb), 10));
    Reset = 1;
    start = 1;
    key = KA;
    repeat (2) tick();
    chk("held_rst_busy", 128'(busy), 128'd0);
    Reset = 0;
    start_key(KA);
    repeat (12) tick();
    for (int n = 0; n < 6; n++) run_exp({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    repeat (3) tick();
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
